// File: rtl/cbtest_pkg.sv
// Shared encodings and helpers for the colour-bar test sequencer.
// Mode inputs, applied-state enum and palette index stepping.
package cbtest_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_MANUAL = 2'b10;

    localparam logic [2:0] PAL_IDX_MIN = 3'd1;
    localparam logic [2:0] PAL_IDX_MAX = 3'd7;

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_AUTO   = 2'd1,
        S_MANUAL = 2'd2
    } state_e;

    // 2'b11 is an alias for HOLD.
    function automatic state_e mode_to_state(input logic [1:0] m);
        case (m)
            MODE_AUTO:   return S_AUTO;
            MODE_MANUAL: return S_MANUAL;
            default:     return S_HOLD;
        endcase
    endfunction

    // Skips index 0 (black).
    function automatic logic [2:0] next_index(input logic [2:0] idx);
        return (idx == PAL_IDX_MAX) ? PAL_IDX_MIN : idx + 3'd1;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Optional flop synchroniser followed by a rising-edge detector.
// SYNC_STAGES=0 detects edges on an input already in the clk domain.
module sync_rise_detect
    import cbtest_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic synced;
    logic prev_q;

    if (SYNC_STAGES == 0) begin : g_direct
        assign synced = din;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES:0]   sync_in;

        assign sync_in = {sync_q, din};

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_in[SYNC_STAGES-1:0];
            end
        end

        assign synced = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= synced;
        end
    end

    assign rise = synced & ~prev_q;

endmodule

// File: rtl/cbtest_frame_sequencer.sv
// Frame-synchronous palette index / tile mode sequencer for the colour-bar test path.
// All settings update only on the edge following the first active vsync cycle.
module cbtest_frame_sequencer
    import cbtest_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned VSYNC_ACT_LOW   = 1,
    parameter int unsigned IDX_RESET       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [1:0] mode,
    input  logic       step_btn,
    output logic [2:0] color_index,
    output logic       tile_en,
    output logic       frame_strobe,
    output logic       step_pending
);

    localparam int unsigned    CntW     = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_STEP - 1);
    localparam logic [2:0]     IdxReset = 3'(IDX_RESET);

    logic vs_act;
    logic boundary;
    logic btn_rise;
    logic adv;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            tile_q, tile_d;
    logic            strobe_q, strobe_d;
    logic            pend_q, pend_d;

    assign vs_act = vsync ^ 1'(VSYNC_ACT_LOW);

    sync_rise_detect #(
        .SYNC_STAGES (0)
    ) u_vs_edge (
        .clk   (clk),
        .reset (reset),
        .din   (vs_act),
        .rise  (boundary)
    );

    sync_rise_detect #(
        .SYNC_STAGES (2)
    ) u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .din   (step_btn),
        .rise  (btn_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            idx_q    <= IdxReset;
            tile_q   <= 1'b0;
            strobe_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tile_q   <= tile_d;
            strobe_q <= strobe_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        tile_d   = tile_q;
        strobe_d = boundary;
        pend_d   = pend_q;
        adv      = 1'b0;

        if (state_q == S_MANUAL && btn_rise) begin
            pend_d = 1'b1;
        end

        if (boundary) begin
            state_d = mode_to_state(mode);
            if (state_d != state_q) begin
                // A mode switch consumes this boundary: no advance, fresh count.
                cnt_d  = '0;
                pend_d = 1'b0;
            end else begin
                unique case (state_q)
                    S_AUTO: begin
                        if (cnt_q == CntLast) begin
                            adv   = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    S_MANUAL: begin
                        if (pend_q) begin
                            adv    = 1'b1;
                            // An edge coinciding with this boundary waits for the next one.
                            pend_d = btn_rise;
                        end
                    end
                    default: begin
                        cnt_d  = '0;
                        pend_d = 1'b0;
                    end
                endcase
            end
        end

        if (adv) begin
            idx_d = next_index(idx_q);
            if (idx_q == PAL_IDX_MAX) begin
                tile_d = ~tile_q;
            end
        end
    end

    assign color_index  = idx_q;
    assign tile_en      = tile_q;
    assign frame_strobe = strobe_q;
    assign step_pending = pend_q;

endmodule

// File: tb/tb_cbtest_frame_sequencer.sv
// Directed bench for cbtest_frame_sequencer: a frame-by-frame vector table plus
// hand sequences for reset, boundary collision, mid-frame mode change and vsync polarity.
module tb_cbtest_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic [1:0] mode;
    logic       step_btn;
    logic [2:0] color_index;
    logic       tile_en;
    logic       frame_strobe;
    logic       step_pending;

    logic       vsync_h;
    logic [1:0] mode_h;
    logic       btn_h;
    logic [2:0] color_index_h;
    logic       tile_en_h;
    logic       frame_strobe_h;
    logic       step_pending_h;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cbtest_frame_sequencer #(
        .FRAMES_PER_STEP (2),
        .VSYNC_ACT_LOW   (1),
        .IDX_RESET       (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .mode         (mode),
        .step_btn     (step_btn),
        .color_index  (color_index),
        .tile_en      (tile_en),
        .frame_strobe (frame_strobe),
        .step_pending (step_pending)
    );

    cbtest_frame_sequencer #(
        .FRAMES_PER_STEP (1),
        .VSYNC_ACT_LOW   (0),
        .IDX_RESET       (7)
    ) dut_hi (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync_h),
        .mode         (mode_h),
        .step_btn     (btn_h),
        .color_index  (color_index_h),
        .tile_en      (tile_en_h),
        .frame_strobe (frame_strobe_h),
        .step_pending (step_pending_h)
    );

    typedef struct {
        logic [1:0] mode;
        int         presses;
        logic [2:0] idx;
        logic       tile;
        logic       pend;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press();
        step_btn = 1'b1;
        repeat (5) tick();
        step_btn = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        // mode, presses in frame, idx/tile after boundary, pending at frame end
        tbl[0] = '{2'b01, 0, 3'd7, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 0, 3'd7, 1'b0, 1'b0};
        tbl[2] = '{2'b01, 0, 3'd1, 1'b1, 1'b0};
        tbl[3] = '{2'b01, 0, 3'd1, 1'b1, 1'b0};
        tbl[4] = '{2'b01, 0, 3'd2, 1'b1, 1'b0};
        tbl[5] = '{2'b10, 3, 3'd2, 1'b1, 1'b1};
        tbl[6] = '{2'b10, 0, 3'd3, 1'b1, 1'b0};
        tbl[7] = '{2'b10, 0, 3'd3, 1'b1, 1'b0};

        reset    = 1'b1;
        vsync    = 1'b1;
        mode     = 2'b00;
        step_btn = 1'b0;
        vsync_h  = 1'b0;
        mode_h   = 2'b01;
        btn_h    = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("por_idx", 8'(color_index), 8'd7);
        check("por_tile", 8'(tile_en), 8'd0);
        check("por_strobe", 8'(frame_strobe), 8'd0);
        check("por_pend", 8'(step_pending), 8'd0);

        // T1: latch a manual step, then reset mid-frame
        mode  = 2'b10;
        vsync = 1'b0;
        tick();
        check("t1_strobe", 8'(frame_strobe), 8'd1);
        tick();
        vsync = 1'b1;
        repeat (3) tick();
        press();
        check("t1_pend_before", 8'(step_pending), 8'd1);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("t1_idx", 8'(color_index), 8'd7);
        check("t1_tile", 8'(tile_en), 8'd0);
        check("t1_pend", 8'(step_pending), 8'd0);
        check("t1_strobe0", 8'(frame_strobe), 8'd0);

        // T2/T3: frame-by-frame table
        for (int i = 0; i < 8; i++) begin
            mode  = tbl[i].mode;
            vsync = 1'b0;
            tick();
            check($sformatf("row%0d_strobe", i), 8'(frame_strobe), 8'd1);
            check($sformatf("row%0d_idx", i), 8'(color_index), 8'(tbl[i].idx));
            check($sformatf("row%0d_tile", i), 8'(tile_en), 8'(tbl[i].tile));
            tick();
            check($sformatf("row%0d_strobe_width", i), 8'(frame_strobe), 8'd0);
            vsync = 1'b1;
            for (int p = 0; p < tbl[i].presses; p++) press();
            repeat (4) tick();
            check($sformatf("row%0d_pend", i), 8'(step_pending), 8'(tbl[i].pend));
        end

        // T4: button rise on the boundary cycle
        step_btn = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        check("t4_strobe", 8'(frame_strobe), 8'd1);
        check("t4_idx_hold", 8'(color_index), 8'd3);
        check("t4_pend_set", 8'(step_pending), 8'd1);
        tick();
        vsync = 1'b1;
        repeat (3) tick();
        step_btn = 1'b0;
        repeat (5) tick();
        check("t4_pend_mid", 8'(step_pending), 8'd1);
        vsync = 1'b0;
        tick();
        check("t4_idx_adv", 8'(color_index), 8'd4);
        check("t4_pend_clr", 8'(step_pending), 8'd0);
        tick();
        vsync = 1'b1;
        repeat (4) tick();

        // T5: AUTO with frame_cnt=1, switch to HOLD mid-frame
        mode  = 2'b01;
        vsync = 1'b0;
        tick();
        check("t5_enter_auto", 8'(color_index), 8'd4);
        tick();
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        tick();
        check("t5_cnt1_idx", 8'(color_index), 8'd4);
        tick();
        vsync = 1'b1;
        repeat (3) tick();
        mode = 2'b00;
        repeat (5) tick();
        check("t5_mid_idx", 8'(color_index), 8'd4);
        check("t5_mid_tile", 8'(tile_en), 8'd1);
        vsync = 1'b0;
        tick();
        check("t5_enter_hold_idx", 8'(color_index), 8'd4);
        for (int f = 0; f < 10; f++) begin
            tick();
            vsync = 1'b1;
            press();
            repeat (3) tick();
            check($sformatf("t5_hold%0d_pend", f), 8'(step_pending), 8'd0);
            vsync = 1'b0;
            tick();
            check($sformatf("t5_hold%0d_strobe", f), 8'(frame_strobe), 8'd1);
            check($sformatf("t5_hold%0d_idx", f), 8'(color_index), 8'd4);
            check($sformatf("t5_hold%0d_tile", f), 8'(tile_en), 8'd1);
        end
        tick();
        vsync = 1'b1;
        tick();

        // T6: active-high vsync, FRAMES_PER_STEP=1
        vsync_h = 1'b1;
        tick();
        check("t6_rise_strobe", 8'(frame_strobe_h), 8'd1);
        check("t6_enter_idx", 8'(color_index_h), 8'd7);
        tick();
        check("t6_strobe_width", 8'(frame_strobe_h), 8'd0);
        repeat (3) tick();
        vsync_h = 1'b0;
        tick();
        check("t6_fall_a", 8'(frame_strobe_h), 8'd0);
        tick();
        check("t6_fall_b", 8'(frame_strobe_h), 8'd0);
        vsync_h = 1'b1;
        tick();
        check("t6_adv1_idx", 8'(color_index_h), 8'd1);
        check("t6_adv1_tile", 8'(tile_en_h), 8'd1);
        tick();
        vsync_h = 1'b0;
        tick();
        vsync_h = 1'b1;
        tick();
        check("t6_adv2_idx", 8'(color_index_h), 8'd2);
        check("t6_adv2_tile", 8'(tile_en_h), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
